// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit. It processes one bit per cycle using
// shift-add multiplication and restoring division on operand magnitudes, then
// applies sign correction in a final FIX state.
module mul_div_unit #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WORDSIZE-1:0] operand_a,
  input  logic [WORDSIZE-1:0] operand_b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result
);

  localparam int CW = $clog2(WORDSIZE);
  localparam logic [CW-1:0]         CNT_LAST = CW'(WORDSIZE - 1);
  localparam logic [WORDSIZE-1:0]   ZERO     = '0;
  localparam logic [WORDSIZE-1:0]   ALL_ONES = '1;
  localparam logic [WORDSIZE-1:0]   ONE      = {{(WORDSIZE-1){1'b0}}, 1'b1};
  localparam logic [2*WORDSIZE-1:0] ONE2     = {{(2*WORDSIZE-1){1'b0}}, 1'b1};
  localparam logic [WORDSIZE-1:0]   MOST_NEG = {1'b1, {(WORDSIZE-1){1'b0}}};
  localparam logic [2:0]            OP_MUL   = 3'b000;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic                  special_q, special_d;
  logic [CW-1:0]         counter_q, counter_d;
  // Product accumulator for multiplies; {remainder, quotient/dividend} for divides.
  // A special-case result is parked in the low half until FIX.
  logic [2*WORDSIZE-1:0] acc_q, acc_d;
  logic [WORDSIZE-1:0]   opa_q, opa_d;
  logic [WORDSIZE-1:0]   opb_q, opb_d;
  logic [WORDSIZE-1:0]   result_q, result_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  a_signed, b_signed, sa, sb, is_div;
  logic [WORDSIZE-1:0]   amag, bmag;
  logic [WORDSIZE:0]     sum, rem_sh, diff;
  logic [2*WORDSIZE-1:0] prod;

  function automatic logic [WORDSIZE-1:0] neg_if(input logic [WORDSIZE-1:0] v,
                                                 input logic n);
    return n ? (~v + ONE) : v;
  endfunction

  // Next-state, datapath iteration and result selection.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    special_d = special_q;
    counter_d = counter_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    is_div    = op[2];
    a_signed  = is_div ? ~op[0] : (op[1:0] != 2'b11);
    b_signed  = is_div ? ~op[0] : ~op[1];
    sa        = a_signed & operand_a[WORDSIZE-1];
    sb        = b_signed & operand_b[WORDSIZE-1];
    amag      = neg_if(operand_a, sa);
    bmag      = neg_if(operand_b, sb);
    sum       = '0;
    rem_sh    = '0;
    diff      = '0;
    prod      = '0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_d      = op;
            sign_a_d  = sa;
            sign_b_d  = sb;
            opa_d     = amag;
            opb_d     = bmag;
            counter_d = '0;
            special_d = 1'b0;
            if (is_div && operand_b == ZERO) begin
              special_d = 1'b1;
              acc_d     = {ZERO, (op[1] ? operand_a : ALL_ONES)};
              state_d   = S_FIX;
            end else if (is_div && !op[0] && operand_a == MOST_NEG && operand_b == ALL_ONES) begin
              special_d = 1'b1;
              acc_d     = {ZERO, (op[1] ? ZERO : operand_a)};
              state_d   = S_FIX;
            end else begin
              acc_d   = {ZERO, (is_div ? amag : bmag)};
              state_d = S_CALC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (!op_q[2]) begin
            sum   = {1'b0, acc_q[2*WORDSIZE-1:WORDSIZE]} + {1'b0, (acc_q[0] ? opa_q : ZERO)};
            acc_d = {sum, acc_q[WORDSIZE-1:1]};
          end else begin
            rem_sh = acc_q[2*WORDSIZE-1:WORDSIZE-1];
            diff   = rem_sh - {1'b0, opb_q};
            if (!diff[WORDSIZE]) acc_d = {diff[WORDSIZE-1:0], acc_q[WORDSIZE-2:0], 1'b1};
            else                 acc_d = {rem_sh[WORDSIZE-1:0], acc_q[WORDSIZE-2:0], 1'b0};
          end
          counter_d = counter_q + CW'(1);
          if (counter_q == CNT_LAST) state_d = S_FIX;
        end
        S_FIX: begin
          if (special_q) begin
            result_d = acc_q[WORDSIZE-1:0];
          end else if (!op_q[2]) begin
            prod     = (sign_a_q ^ sign_b_q) ? (~acc_q + ONE2) : acc_q;
            result_d = (op_q == OP_MUL) ? prod[WORDSIZE-1:0] : prod[2*WORDSIZE-1:WORDSIZE];
          end else if (!op_q[1]) begin
            result_d = neg_if(acc_q[WORDSIZE-1:0], sign_a_q ^ sign_b_q);
          end else begin
            result_d = neg_if(acc_q[2*WORDSIZE-1:WORDSIZE], sign_a_q);
          end
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      counter_q <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      special_q <= special_d;
      counter_q <= counter_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit (WORDSIZE = 64).
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [63:0] operand_a;
  logic [63:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mul_div_unit #(.WORDSIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents one request for a single edge; t0 is the cycle index of the start edge.
  task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       output int t0);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  // Returns cycles from the start edge until done is seen, or -1 after 200 cycles.
  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      tick();
      if (done) lat = cyc - t0;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res);
    int t0, lat;
    issue(o, a, b, t0);
    wait_done(t0, lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s_result: got %h expected %h", name, result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000;
    operand_a = '0; operand_b = '0;
    tick(); tick();
    checks++;
    if ({busy, done, result} !== 66'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int t0, lat, ndone;
    issue(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, t0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mul_busy: got %b expected 1", busy);
    end
    wait_done(t0, lat);
    checks++;
    if (lat !== 65) begin
      errors++;
      $display("FAIL mul_latency: got %0d expected 65", lat);
    end
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL mul_result: got %h expected %h", result, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_once: got extra_done=%0d busy=%b expected 0 0", ndone, busy);
    end
  endtask

  task automatic test_mulh_variants();
    run_op("mulhu",  3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulh",   3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'h0);
    run_op("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    int t0, lat;
    run_op("div", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    // Still in the done cycle: request REM immediately.
    issue(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, t0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b expected 1", busy);
    end
    wait_done(t0, lat);
    checks++;
    if (lat !== 65) begin
      errors++;
      $display("FAIL rem_latency: got %0d expected 65", lat);
    end
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL rem_result: got %h expected %h", result, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    tick();
  endtask

  task automatic test_special();
    run_op("divu_by0", 3'b101, 64'd123, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_by0", 3'b111, 64'd123, 64'd0, 1, 64'd123);
    run_op("div_ovf",  3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000);
    run_op("rem_ovf",  3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0);
    tick();
  endtask

  task automatic test_ignore_start();
    int t0, lat;
    issue(3'b101, 64'd1000, 64'd7, t0);
    while (cyc - t0 < 10) tick();
    op = 3'b101; operand_a = 64'd5; operand_b = 64'd1; start = 1'b1;
    tick();
    start = 1'b0; operand_a = 64'd99; operand_b = 64'd3;
    wait_done(t0, lat);
    checks++;
    if (lat !== 65) begin
      errors++;
      $display("FAIL ignore_start_latency: got %0d expected 65", lat);
    end
    checks++;
    if (result !== 64'd142) begin
      errors++;
      $display("FAIL ignore_start_result: got %0d expected 142", result);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    int t0, ndone;
    issue(3'b101, 64'd1000, 64'd7, t0);
    while (cyc - t0 < 30) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result} !== 66'b0) begin
      errors++;
      $display("FAIL reset_midop: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || result !== 64'h0) begin
      errors++;
      $display("FAIL reset_no_done: got done_count=%0d result=%h expected 0 0", ndone, result);
    end
  endtask

  task automatic test_flush();
    int t0, ndone;
    run_op("pre_flush", 3'b101, 64'd123, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    issue(3'b000, 64'd3, 64'd5, t0);
    while (cyc - t0 < 19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL flush_hold: got done_count=%0d result=%h expected 0 %h", ndone, result, 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_flush_start();
    int ndone;
    op = 3'b000; operand_a = 64'd4; operand_b = 64'd4;
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_busy: got %b expected 0", busy);
    end
    ndone = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL flush_start_hold: got done_count=%0d result=%h expected 0 %h", ndone, result, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    run_op("post_flush_mul", 3'b000, 64'd6, 64'd7, 65, 64'd42);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh_variants();
    test_back_to_back();
    test_special();
    test_ignore_start();
    test_reset_midop();
    test_flush();
    test_flush_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
